// File: rtl/reg_read_arb_pkg.sv
// Shared types and elaboration helpers for the register-file read-port arbiter.
package reg_read_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rra_state_e;

  // Forced grant must be reachable: the counter has to be able to hold the bound.
  function automatic bit starve_max_legal(input int starve_max, input int cnt_w);
    return (starve_max >= 1) && (starve_max <= 15) && (starve_max < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/reg_read_arbiter_if.sv
// Secondary (syscall/debug) read channel: request/grant in, valid/ready response out.
interface reg_read_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rready;

  modport master (
    output dbg_req, dbg_addr, dbg_rready,
    input  dbg_gnt, dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_addr, dbg_rready,
    output dbg_gnt, dbg_rvalid, dbg_rdata
  );
endinterface

// File: rtl/rra_starve_counter.sv
// Saturating count of denied WAIT cycles; at_max requests a forced port-2 grant.
// One-cycle update latency; clear has priority over enable.
module rra_starve_counter #(
  parameter int CNT_W = 4,
  parameter int MAX   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/reg_read_arbiter.sv
// Lends regfile read port 2 to a debug requester when ID leaves it free, or forces it after STARVE_MAX denials.
// Latency: read 1..1+STARVE_MAX cycles after grant, response the cycle after; forced read stalls ID one cycle.
// Backpressure: response held in RESP until dbg_rready; no grant while held. RRA_STALL_CNT_EN adds stall_cnt.
module reg_read_arbiter
  import reg_read_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_r1,
  input  logic [ADDR_W-1:0] id_r2,
  input  logic              id_r2_used,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              id_stall,
`ifdef RRA_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  reg_read_arbiter_if.slave dbg
);

  if (!starve_max_legal(STARVE_MAX, CNT_W)) begin : g_bad_starve_max
    $error("reg_read_arbiter: STARVE_MAX must be 1..15 and fit in CNT_W");
  end

  rra_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              port2_free;
  logic              at_max;
  logic              perform;
  logic              gnt;
  logic              cnt_en;
  logic              rvalid;

  // Port-1 data feeds the ID datapath directly; kept here for a uniform regfile boundary.
  logic unused_rd1;
  assign unused_rd1 = ^rf_rd1;

  assign port2_free = !id_valid || !id_r2_used;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dbg.dbg_req) state_d = WAIT;
      WAIT:    if (port2_free || at_max) state_d = RESP;
      RESP:    if (dbg.dbg_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so nothing is granted or stalled while reset is held.
  always_comb begin
    gnt      = 1'b0;
    perform  = 1'b0;
    id_stall = 1'b0;
    cnt_en   = 1'b0;
    rvalid   = 1'b0;
    case (state_q)
      IDLE: gnt = rst_n && dbg.dbg_req;
      WAIT: begin
        if (rst_n) begin
          if (port2_free) begin
            perform = 1'b1;
          end else if (at_max) begin
            perform  = 1'b1;
            id_stall = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      RESP:    rvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (gnt) addr_q <= dbg.dbg_addr;
      if (perform) rdata_q <= rf_rd2;
    end
  end

  rra_starve_counter #(
    .CNT_W (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (gnt),
    .en     (cnt_en),
    .at_max (at_max)
  );

`ifdef RRA_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign rf_ra1         = id_r1;
  assign rf_ra2         = perform ? addr_q : id_r2;
  assign dbg.dbg_gnt    = gnt;
  assign dbg.dbg_rvalid = rvalid;
  assign dbg.dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed cycle table plus forced-grant sequences for reg_read_arbiter; regfile word i holds i*5.
module tb_reg_read_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_r1, id_r2;
  logic        id_r2_used;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        id_stall;
`ifdef RRA_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  logic [31:0] regs [32];

  int n_vec = 0;
  int n_err = 0;

  reg_read_arbiter_if #(.ADDR_W(5), .DATA_W(32)) dbg_if ();

  reg_read_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SM), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_r1      (id_r1),
    .id_r2      (id_r2),
    .id_r2_used (id_r2_used),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .id_stall   (id_stall),
`ifdef RRA_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .dbg        (dbg_if)
  );

  always #5 clk = ~clk;

  always_comb begin
    rf_rd1 = regs[rf_ra1];
    rf_rd2 = regs[rf_ra2];
  end

  typedef struct {
    logic        rst;
    logic        idv;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        used;
    logic        req;
    logic [4:0]  addr;
    logic        rdy;
    logic [4:0]  ra2;
    logic        stall;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic idv, input logic [4:0] r1, input logic [4:0] r2,
                     input logic used, input logic req, input logic [4:0] addr, input logic rdy,
                     input logic [4:0] ra2, input logic stall, input logic gnt, input logic rv,
                     input logic [31:0] rdata);
    vec_t v;
    v = '{rst, idv, r1, r2, used, req, addr, rdy, ra2, stall, gnt, rv, rdata};
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic forced_read(input logic [4:0] a);
    int stalls = 0;
    int stall_at = -1;
    int rv_at = -1;
    @(posedge clk); #1;
    id_valid = 1'b1; id_r2_used = 1'b1; id_r1 = 5'd1; id_r2 = 5'd3;
    dbg_if.dbg_req = 1'b1; dbg_if.dbg_addr = a; dbg_if.dbg_rready = 1'b0;
    @(negedge clk);
    chk("fr_gnt", a, dbg_if.dbg_gnt, 1);
    @(posedge clk); #1;
    dbg_if.dbg_req = 1'b0; dbg_if.dbg_addr = 5'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (id_stall) begin
        stalls++;
        stall_at = k;
        chk("fr_ra2", a, rf_ra2, a);
      end
      if (dbg_if.dbg_rvalid) begin
        rv_at = k;
        break;
      end
      @(posedge clk);
    end
    chk("fr_rvalid_seen", a, (rv_at >= 0), 1);
    chk("fr_stall_count", a, stalls, 1);
    chk("fr_stall_cycle", a, stall_at, SM + 1);
    chk("fr_rvalid_cycle", a, rv_at, SM + 2);
    chk("fr_rdata", a, dbg_if.dbg_rdata, 32'(a) * 32'd5);
    dbg_if.dbg_rready = 1'b1;
    @(posedge clk); #1;
    dbg_if.dbg_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'd5;

    rst_n = 1'b0; id_valid = 1'b0; id_r1 = 5'd0; id_r2 = 5'd0; id_r2_used = 1'b0;
    dbg_if.dbg_req = 1'b1; dbg_if.dbg_addr = 5'd3; dbg_if.dbg_rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 0, dbg_if.dbg_gnt, 0);
    chk("rst_rvalid", 0, dbg_if.dbg_rvalid, 0);
    chk("rst_rdata", 0, dbg_if.dbg_rdata, 0);
    chk("rst_stall", 0, id_stall, 0);

    //  rst idv r1 r2 used req addr rdy | ra2 stall gnt rv rdata
    // ID idle: grant, free read of reg 2, response consumed at once; no same-cycle regrant.
    add(1, 0, 1, 7, 0, 1, 2, 0,   7, 0, 1, 0, 0);
    add(1, 0, 1, 7, 0, 0, 0, 0,   2, 0, 0, 0, 0);
    add(1, 0, 1, 7, 0, 1, 5, 1,   7, 0, 0, 1, 10);
    add(1, 0, 1, 7, 0, 1, 5, 0,   7, 0, 1, 0, 10);
    // Valid instruction not using port 2 still frees it; then 5 held RESP cycles ignore requests.
    add(1, 1, 2, 9, 0, 0, 0, 0,   5, 0, 0, 0, 10);
    for (int i = 0; i < 5; i++) add(1, 1, 2, 9, 1, 1, 6, 0,   9, 0, 0, 1, 25);
    add(1, 1, 2, 9, 1, 0, 0, 1,   9, 0, 0, 1, 25);
    add(1, 1, 2, 9, 1, 0, 0, 0,   9, 0, 0, 0, 25);
    // Contended for 2 cycles, then port frees up.
    add(1, 1, 1, 3, 1, 1, 6, 0,   3, 0, 1, 0, 25);
    add(1, 1, 1, 3, 1, 0, 0, 0,   3, 0, 0, 0, 25);
    add(1, 1, 1, 3, 1, 0, 0, 0,   3, 0, 0, 0, 25);
    add(1, 1, 1, 3, 0, 0, 0, 0,   6, 0, 0, 0, 25);
    add(1, 1, 1, 3, 1, 0, 0, 1,   3, 0, 0, 1, 30);
    // Address 0 reads as zero.
    add(1, 0, 1, 3, 0, 1, 0, 0,   3, 0, 1, 0, 30);
    add(1, 0, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 30);
    add(1, 0, 1, 3, 0, 0, 0, 1,   3, 0, 0, 1, 0);
    // Fully contended: STARVE_MAX denials (counter restarted), one forced stall cycle.
    add(1, 1, 1, 3, 1, 1, 4, 0,   3, 0, 1, 0, 0);
    for (int i = 0; i < SM; i++) add(1, 1, 1, 3, 1, 0, 0, 0,   3, 0, 0, 0, 0);
    add(1, 1, 1, 3, 1, 0, 0, 0,   4, 1, 0, 0, 0);
    add(1, 1, 1, 3, 1, 0, 0, 1,   3, 0, 0, 1, 20);
    // Reset during WAIT: back to IDLE, captured data cleared.
    add(1, 1, 1, 3, 1, 1, 7, 0,   3, 0, 1, 0, 20);
    add(1, 1, 1, 3, 1, 0, 0, 0,   3, 0, 0, 0, 20);
    add(0, 1, 1, 3, 1, 1, 2, 0,   3, 0, 0, 0, 20);
    add(1, 0, 1, 3, 0, 0, 0, 0,   3, 0, 0, 0, 0);
    // Reset during RESP discards the response.
    add(1, 0, 1, 3, 0, 1, 2, 0,   3, 0, 1, 0, 0);
    add(1, 0, 1, 3, 0, 0, 0, 0,   2, 0, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0, 0, 0,   3, 0, 0, 1, 10);
    add(1, 0, 1, 3, 0, 0, 0, 0,   3, 0, 0, 0, 0);
    // Request under reset is not accepted.
    add(0, 0, 1, 3, 0, 1, 2, 0,   3, 0, 0, 0, 0);
    add(1, 0, 1, 3, 0, 0, 0, 0,   3, 0, 0, 0, 0);

    foreach (tv[i]) begin
      @(posedge clk); #1;
      rst_n = tv[i].rst; id_valid = tv[i].idv; id_r1 = tv[i].r1; id_r2 = tv[i].r2;
      id_r2_used = tv[i].used; dbg_if.dbg_req = tv[i].req; dbg_if.dbg_addr = tv[i].addr;
      dbg_if.dbg_rready = tv[i].rdy;
      @(negedge clk);
      chk("ra1", i, rf_ra1, tv[i].r1);
      chk("ra2", i, rf_ra2, tv[i].ra2);
      chk("stall", i, id_stall, tv[i].stall);
      chk("gnt", i, dbg_if.dbg_gnt, tv[i].gnt);
      chk("rvalid", i, dbg_if.dbg_rvalid, tv[i].rv);
      chk("rdata", i, dbg_if.dbg_rdata, tv[i].rdata);
    end

`ifdef RRA_STALL_CNT_EN
    chk("stall_cnt_after_table", 0, stall_cnt, 0);
`endif
    forced_read(5'd9);
    forced_read(5'd17);
    forced_read(5'd31);
`ifdef RRA_STALL_CNT_EN
    @(negedge clk);
    chk("stall_cnt_3", 0, stall_cnt, 3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("stall_cnt_rst", 0, stall_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
